// File: rtl/sop_conv_engine_if.sv
// Handshake bundle for sop_conv_engine: window/kernel pair in, feature value out.
// The slave modport is the engine; the master modport is the window generator
// and writeback side.
interface sop_conv_engine_if #(
    parameter int KDIM   = 7,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16
);
    localparam int N = KDIM * KDIM;

    logic [N*DATA_W-1:0] kernel_patch;
    logic [N*DATA_W-1:0] pixel_window;
    logic                signed_mode;
    logic                in_valid;
    logic                in_ready;
    logic [OUT_W-1:0]    out_val;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    modport slave (
        input  kernel_patch, pixel_window, signed_mode, in_valid, out_ready,
        output in_ready, out_val, out_valid, busy
    );

    modport master (
        output kernel_patch, pixel_window, signed_mode, in_valid, out_ready,
        input  in_ready, out_val, out_valid, busy
    );
endinterface

// File: rtl/sop_conv_engine.sv
// sop_conv_engine: KDIM x KDIM sum-of-products, LANES products per beat,
// accumulated over CHANNELS windows, one OUT_W result per group.
// Optional feature: define SOP_SATURATE_EN to clamp the result to the OUT_W
// range (signed or unsigned by mode); otherwise the low OUT_W bits are emitted.

// One multiplier lane: kernel element is signed or unsigned by mode, pixel is
// always unsigned. Both are widened to the full product width before the
// multiply so the product is exact.
module sop_mac_lane #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   kern,
    input  logic [DATA_W-1:0]   pix,
    input  logic                signed_mode,
    output logic [2*DATA_W+1:0] prod
);
    localparam int PROD_W = 2*DATA_W + 2;

    logic                     k_msb;
    logic signed [PROD_W-1:0] k_w;
    logic signed [PROD_W-1:0] p_w;

    assign k_msb = signed_mode & kern[DATA_W-1];
    assign k_w   = {{(DATA_W+2){k_msb}}, kern};
    assign p_w   = {{(DATA_W+2){1'b0}}, pix};
    assign prod  = k_w * p_w;
endmodule

module sop_conv_engine #(
    parameter int KDIM     = 7,
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 16,
    parameter int LANES    = 7,
    parameter int CHANNELS = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    sop_conv_engine_if.slave  io
);
    localparam int N      = KDIM * KDIM;
    localparam int BEATS  = (N + LANES - 1) / LANES;
    localparam int PROD_W = 2*DATA_W + 2;
    localparam int ACC_W  = PROD_W + $clog2(N * CHANNELS);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, MAC, WAIT_CH, OUT} state_t;

    state_t                     state_q, state_d;
    logic [N*DATA_W-1:0]        kern_q, pix_q;
    logic                       signed_q;
    logic signed [ACC_W-1:0]    acc_q, acc_nxt, beat_sum;
    logic [BEAT_W-1:0]          beat_q;
    logic [CH_W-1:0]            ch_q;
    logic [OUT_W-1:0]           out_val_q, res_fmt;
    logic                       accept, last_beat, last_ch;

    // Latched vectors regrouped as [beat][lane]; slots past N read as zero so
    // a short final beat contributes nothing.
    logic [BEATS-1:0][LANES-1:0][DATA_W-1:0] kern_pad, pix_pad;
    logic [LANES-1:0][PROD_W-1:0]            prod;

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        for (genvar l = 0; l < LANES; l++) begin : g_slot
            localparam int IDX = b*LANES + l;
            if (IDX < N) begin : g_live
                assign kern_pad[b][l] = kern_q[IDX*DATA_W +: DATA_W];
                assign pix_pad[b][l]  = pix_q[IDX*DATA_W +: DATA_W];
            end else begin : g_pad
                assign kern_pad[b][l] = '0;
                assign pix_pad[b][l]  = '0;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sop_mac_lane #(.DATA_W(DATA_W)) u_lane (
            .kern        (kern_pad[beat_q][l]),
            .pix         (pix_pad[beat_q][l]),
            .signed_mode (signed_q),
            .prod        (prod[l])
        );
    end

    assign accept    = io.in_valid && io.in_ready;
    assign last_beat = (beat_q == BEAT_W'(BEATS-1));
    assign last_ch   = (ch_q == CH_W'(CHANNELS-1));

    // Sign-extend each lane product and add this beat's contribution.
    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < LANES; l++)
            beat_sum = beat_sum + {{(ACC_W-PROD_W){prod[l][PROD_W-1]}}, prod[l]};
        acc_nxt = acc_q + beat_sum;
    end

    // Reduce the final accumulator to the output width.
`ifdef SOP_SATURATE_EN
    localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] U_MAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    always_comb begin
        res_fmt = acc_nxt[OUT_W-1:0];
        if (signed_q) begin
            if (acc_nxt > S_MAX)      res_fmt = S_MAX[OUT_W-1:0];
            else if (acc_nxt < S_MIN) res_fmt = S_MIN[OUT_W-1:0];
        end else begin
            if (acc_nxt < 0)          res_fmt = '0;
            else if (acc_nxt > U_MAX) res_fmt = U_MAX[OUT_W-1:0];
        end
    end
`else
    always_comb res_fmt = acc_nxt[OUT_W-1:0];
`endif

    // Next-state decode; in_ready is a pure function of state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MAC;
            MAC:     if (last_beat) state_d = last_ch ? OUT : WAIT_CH;
            WAIT_CH: if (accept) state_d = MAC;
            OUT:     if (io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Datapath: latch on accept, accumulate per beat, capture result at group end.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            kern_q    <= '0;
            pix_q     <= '0;
            signed_q  <= 1'b0;
            acc_q     <= '0;
            beat_q    <= '0;
            ch_q      <= '0;
            out_val_q <= '0;
        end else begin
            if (accept) begin
                kern_q <= io.kernel_patch;
                pix_q  <= io.pixel_window;
                beat_q <= '0;
                // A new group starts from IDLE; WAIT_CH keeps the running sum and mode.
                if (state_q == IDLE) begin
                    acc_q    <= '0;
                    ch_q     <= '0;
                    signed_q <= io.signed_mode;
                end
            end
            if (state_q == MAC) begin
                acc_q  <= acc_nxt;
                beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                if (last_beat && !last_ch) ch_q <= ch_q + CH_W'(1);
                if (last_beat && last_ch)  out_val_q <= res_fmt;
            end
        end
    end

    assign io.in_ready  = (state_q == IDLE) || (state_q == WAIT_CH);
    assign io.out_valid = (state_q == OUT);
    assign io.busy      = (state_q != IDLE);
    assign io.out_val   = out_val_q;
endmodule
